mem_arbiter: RTL
================

# mem_arbiter

Round-robin arbiter that shares one synchronous single-port word memory between the instruction-fetch requester and the data (load/store) requester of the multicycle core. It replaces the direct control-unit drive of the memory enables with a req/ack handshake, so fetch and data accesses are serialized and never overlap. It sits between the control unit/datapath and the memory macro; the memory has 1-cycle read latency.

## Interface
- ADDR_W, 10, word-address width driven to memory (byte address bits [ADDR_W+1:2])
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse: fetch complete, rdata valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse: data access complete (rdata valid for loads)
- rdata  out  32  read data, valid only in the ack cycle, held otherwise
- err  out  1  pulses with the ack when addr[1:0] != 0
- busy  out  1  high in ACCESS and RESP
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid cycle after mem_en

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: eligible = req high and that port's ack not high this cycle (requester drops req in its ack cycle; prevents double issue). If any eligible: pick winner, latch addr/we/wdata/port, set mem_en=1, mem_we=(winner is data & d_we), go ACCESS. Fetch never writes.
- Pick: one eligible -> it wins. Both -> port not granted last; last_grant resets to data so fetch wins first contention.
- ACCESS: memory samples at end of cycle; next: mem_en=mem_we=0, go RESP.
- RESP: at end of cycle rdata<=mem_rdata (loads/fetch; stores leave rdata unchanged), pulse winner's ack, err=misaligned, update last_grant, go IDLE.
- Misaligned: access still performed at addr[ADDR_W+1:2] (low bits dropped); err flags it.
- Address bits above ADDR_W+1 ignored (wrap-around within memory).
- Requests changing while unacked: unsupported; latched values used.

## Timing
- All outputs registered. Reset values: if_ack=0, d_ack=0, rdata=0, err=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Latency: req seen in cycle N (IDLE) -> mem_en cycle N+1 -> mem_rdata cycle N+2 -> ack/rdata cycle N+3.
- Throughput: one access per 3 cycles; new grant may be issued in the ack cycle (to the other port, or same port if its req was re-raised after a gap).
- Simultaneous requests in IDLE: round-robin as above; loser waits exactly 3 cycles.
- rst_n low at any time: immediate return to IDLE, all outputs to reset values, in-flight access dropped (store may or may not have landed); requesters must reissue.

## Structure
- Package mem_arb_pkg: state enum typedef (IDLE, ACCESS, RESP), port id localparams (PORT_IF=0, PORT_D=1).
- One sub-module: rr_pick2 (combinational 2-way round-robin select from eligibility and last_grant).
- Memory model in bench only; arbiter contains no storage array.

## Test plan
- Fetch only: if_req, if_addr=0x8 -> mem_addr=2 in cycle 1, if_ack and rdata=mem[2] in cycle 3, err=0.
- Store then load: d_req, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> d_ack cycle 3; then load 0x10 -> rdata=0xDEADBEEF.
- Contention from reset: if_req and d_req both high cycle 0 -> if_ack cycle 3, d_ack cycle 6; repeat contention -> order alternates.
- Misaligned load d_addr=0x13 -> mem_addr=4, d_ack with err=1, rdata=mem[4].
- Reset mid-access: assert rst_n=0 in ACCESS -> mem_en, busy, acks 0 same cycle; after release, held if_req completes in 3 cycles.
- Held req in ack cycle: if_req stays high during if_ack -> no second grant that cycle; grant issued next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // A byte address is misaligned when its low two bits are not zero.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles both requester handshakes and the memory macro bus of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, d_ack, rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, d_ack, rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin select: a lone eligible port wins, and on a tie the
// port that was not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_port
);

    // Resolve the winner from eligibility and the previous grant.
    always_comb begin
        grant_valid = |eligible;
        grant_port  = PORT_IF;
        if (eligible == 2'b11) begin
            grant_port = (last_grant == PORT_D) ? PORT_IF : PORT_D;
        end else if (eligible[PORT_D]) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes instruction fetch and data accesses onto one single-port word
// memory with a 1-cycle read latency, using a three-state grant/access/response
// sequence and round-robin selection between the two requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       last_grant;
    logic       cur_port;
    logic       cur_store;
    logic       cur_mis;

    logic [1:0]        eligible;
    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] sel_word;
    logic [1:0]        sel_low;

    // A port whose ack is high this cycle is about to drop its request, so it
    // must not be granted again on the stale request.
    always_comb begin
        eligible[PORT_IF] = bus.if_req & ~bus.if_ack;
        eligible[PORT_D]  = bus.d_req  & ~bus.d_ack;
    end

    rr_pick2 u_pick (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Word address and alignment bits of the winning requester; upper address
    // bits are dropped so accesses wrap around inside the memory.
    always_comb begin
        if (grant_port == PORT_D) begin
            sel_word = bus.d_addr[ADDR_W+1:2];
            sel_low  = bus.d_addr[1:0];
        end else begin
            sel_word = bus.if_addr[ADDR_W+1:2];
            sel_low  = bus.if_addr[1:0];
        end
    end

    // Grant, drive the memory for one cycle, then capture the read data and
    // pulse the winner's ack; every output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= PORT_D;
            cur_port      <= PORT_IF;
            cur_store     <= 1'b0;
            cur_mis       <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.rdata     <= '0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_port     <= grant_port;
                        cur_store    <= (grant_port == PORT_D) && bus.d_we;
                        cur_mis      <= is_misaligned(sel_low);
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= (grant_port == PORT_D) && bus.d_we;
                        bus.mem_addr <= sel_word;
                        if (grant_port == PORT_D) begin
                            bus.mem_wdata <= bus.d_wdata;
                        end
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (!cur_store) begin
                        bus.rdata <= bus.mem_rdata;
                    end
                    if (cur_port == PORT_D) begin
                        bus.d_ack <= 1'b1;
                    end else begin
                        bus.if_ack <= 1'b1;
                    end
                    bus.err    <= cur_mis;
                    last_grant <= cur_port;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
